// File: rtl/mips_load_pkg.sv
// mips_load_pkg -- shared types and helpers for the MIPS load controller.
//
// Contents:
//   load_op_t     : load type encoded as MIPS opcode[2:0]
//   state_t       : controller FSM states (IDLE, READ, DONE)
//   ERR_*         : completion status codes reported on err
//   op_is_legal   : whether a load type is executable in this build
//   op_misaligned : whether a load type/byte offset pair violates alignment
//
// Build option: UNALIGNED_LOAD_EN -- when defined, LWL/LWR are legal loads;
// otherwise they are reported as illegal operations.
package mips_load_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LWL = 3'b010,
        OP_LW  = 3'b011,
        OP_LBU = 3'b100,
        OP_LHU = 3'b101,
        OP_LWR = 3'b110,
        OP_ILL = 3'b111
    } load_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    function automatic logic op_is_legal(input load_op_t o);
        logic legal;
        legal = 1'b1;
        if (o == OP_ILL) begin
            legal = 1'b0;
        end
`ifdef UNALIGNED_LOAD_EN
`else
        // LWL/LWR are reported illegal when the merge path is absent.
        if (o == OP_LWL || o == OP_LWR) begin
            legal = 1'b0;
        end
`endif
        return legal;
    endfunction

    function automatic logic op_misaligned(input load_op_t o, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (o)
            OP_LH, OP_LHU: mis = off[0];
            OP_LW:         mis = (off != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_load_controller_if.sv
// mem_load_controller_if -- word-oriented memory read bus.
//
// Signals:
//   mem_read        : read strobe, held until the read is accepted
//   mem_address     : word-aligned byte address
//   mem_byteenable  : lane enables (all lanes for a word read)
//   mem_waitrequest : slave stall; a read completes on an edge where it is low
//   mem_readdata    : little-endian read data (offset 0 = bits 7:0)
// Modports: master (load controller) and slave (memory).
interface mem_load_controller_if;

    logic        mem_read;
    logic [31:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;

    modport master (
        output mem_read,
        output mem_address,
        output mem_byteenable,
        input  mem_waitrequest,
        input  mem_readdata
    );

    modport slave (
        input  mem_read,
        input  mem_address,
        input  mem_byteenable,
        output mem_waitrequest,
        output mem_readdata
    );

endinterface

// File: rtl/load_extend.sv
// load_extend -- combinational lane select, extension and partial-word merge.
//
// Ports:
//   op     : load type
//   offset : byte offset within the word (addr[1:0])
//   word   : aligned memory word, little-endian lanes
//   rt_old : previous destination register value (LWL/LWR merge source)
//   result : extended or merged load value
//
// Build option: UNALIGNED_LOAD_EN enables the LWL/LWR merge paths; without
// it those ops produce 0 here (the controller flags them illegal anyway).
module load_extend
    import mips_load_pkg::*;
(
    input  load_op_t    op,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] rt_old,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[7:0];
        case (offset)
            2'd0: byte_lane = word[7:0];
            2'd1: byte_lane = word[15:8];
            2'd2: byte_lane = word[23:16];
            2'd3: byte_lane = word[31:24];
            default: byte_lane = word[7:0];
        endcase
    end

    assign half_lane = offset[1] ? word[31:16] : word[15:0];

`ifdef UNALIGNED_LOAD_EN
    // LWL shifts the word up by 8*(3-k); 3-k on two bits is simply ~k.
    logic [4:0] lwl_sh;
    logic [4:0] lwr_sh;
    assign lwl_sh = {~offset, 3'b000};
    assign lwr_sh = {offset, 3'b000};

    always_comb begin
        result = '0;
        case (op)
            OP_LB:   result = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  result = {24'h0, byte_lane};
            OP_LH:   result = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  result = {16'h0, half_lane};
            OP_LW:   result = word;
            // Keep the low 8*(3-k) bits of rt_old below the shifted word.
            OP_LWL:  result = (word << lwl_sh) | (rt_old & ~(32'hFFFF_FFFF << lwl_sh));
            // Keep the high 8*k bits of rt_old above the shifted word.
            OP_LWR:  result = (word >> lwr_sh) | (rt_old & ~(32'hFFFF_FFFF >> lwr_sh));
            default: result = '0;
        endcase
    end
`else
    logic unused_rt_old;
    assign unused_rt_old = ^rt_old;

    always_comb begin
        result = '0;
        case (op)
            OP_LB:   result = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  result = {24'h0, byte_lane};
            OP_LH:   result = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  result = {16'h0, half_lane};
            OP_LW:   result = word;
            default: result = '0;
        endcase
    end
`endif

endmodule

// File: rtl/mem_load_controller.sv
// mem_load_controller -- executes one MIPS load per request over a stalling
// word-read bus, with alignment/legality checking and a stall timeout.
//
// Ports:
//   clk, reset    : clock; asynchronous active-high reset
//   start         : load request, accepted only while idle
//   op, addr      : load type and effective byte address (sampled with start)
//   rt_old        : destination register value for LWL/LWR merges
//   busy          : high whenever not idle
//   done          : one-cycle completion pulse
//   result, err   : load value and status, valid while done (0 otherwise)
//   mem           : memory read bus (master side)
//
// Parameter TIMEOUT_CYCLES (1..255): consecutive stalled edges tolerated in
// READ before the load is abandoned with ERR_TIMEOUT.
// Build option: UNALIGNED_LOAD_EN enables LWL/LWR; otherwise they are illegal.
module mem_load_controller
    import mips_load_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [2:0]                   op,
    input  logic [31:0]                  addr,
    input  logic [31:0]                  rt_old,
    output logic                         busy,
    output logic                         done,
    output logic [31:0]                  result,
    output logic [1:0]                   err,
    mem_load_controller_if.master        mem
);

    state_t      state_q, state_d;
    load_op_t    op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rt_old_q, rt_old_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] result_q, result_d;
    logic [1:0]  err_q, err_d;

    logic [31:0] ext_result;
    load_op_t    op_in;

    assign op_in = load_op_t'(op);

    load_extend u_extend (
        .op     (op_q),
        .offset (addr_q[1:0]),
        .word   (mem.mem_readdata),
        .rt_old (rt_old_q),
        .result (ext_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_LB;
            addr_q     <= '0;
            rt_old_q   <= '0;
            wait_cnt_q <= '0;
            result_q   <= '0;
            err_q      <= ERR_OK;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            rt_old_q   <= rt_old_d;
            wait_cnt_q <= wait_cnt_d;
            result_q   <= result_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        rt_old_d   = rt_old_q;
        wait_cnt_d = wait_cnt_q;
        result_d   = result_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d       = op_in;
                    addr_d     = addr;
                    rt_old_d   = rt_old;
                    wait_cnt_d = '0;
                    result_d   = '0;
                    // Rejected requests finish without touching memory.
                    if (!op_is_legal(op_in)) begin
                        err_d   = ERR_ILLEGAL;
                        state_d = ST_DONE;
                    end else if (op_misaligned(op_in, addr[1:0])) begin
                        err_d   = ERR_MISALIGN;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (!mem.mem_waitrequest) begin
                    result_d = ext_result;
                    err_d    = ERR_OK;
                    state_d  = ST_DONE;
                end else if (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    // This stalled edge is the TIMEOUT_CYCLES-th in a row.
                    result_d = '0;
                    err_d    = ERR_TIMEOUT;
                    state_d  = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus outputs decode straight from the state flop so an asynchronous
    // reset removes the read strobe without waiting for a clock edge.
    assign busy               = (state_q != ST_IDLE);
    assign done               = (state_q == ST_DONE);
    assign result             = done ? result_q : 32'h0;
    assign err                = done ? err_q : ERR_OK;
    assign mem.mem_read       = (state_q == ST_READ);
    assign mem.mem_address    = mem.mem_read ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem.mem_byteenable = mem.mem_read ? 4'b1111 : 4'b0000;

endmodule

// File: tb/tb_mem_load_controller.sv
module tb_mem_load_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] rt_old;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  err;

    int checks;
    int failures;

    mem_load_controller_if mem_bus ();

    mem_load_controller #(.TIMEOUT_CYCLES(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .addr   (addr),
        .rt_old (rt_old),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err),
        .mem    (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request and plays the memory slave. lat counts edges from
    // the accepting edge N to the edge that samples done (0 = never seen).
    task automatic run_load(input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] rt, input logic [31:0] rd,
                            input int stalls, output int lat,
                            output logic [31:0] res, output logic [1:0] e,
                            output bit read_seen, output bit bus_bad);
        int stall_cnt;
        lat = 0; res = '0; e = '0; read_seen = 0; bus_bad = 0; stall_cnt = 0;
        @(negedge clk);
        start = 1'b1; op = o; addr = a; rt_old = rt;
        mem_bus.mem_readdata = rd; mem_bus.mem_waitrequest = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (mem_bus.mem_read) begin
                read_seen = 1;
                if (mem_bus.mem_address !== {a[31:2], 2'b00} || mem_bus.mem_byteenable !== 4'hF)
                    bus_bad = 1;
                mem_bus.mem_waitrequest = (stall_cnt < stalls);
                if (mem_bus.mem_waitrequest) stall_cnt++;
            end
            if (done) begin
                lat = k; res = result; e = err;
                break;
            end
            @(posedge clk); #1;
        end
        mem_bus.mem_waitrequest = 1'b0;
        $display("load op=%0d addr=%h rd=%h stalls=%0d -> result=%h err=%0d lat=%0d read=%0d",
                 o, a, rd, stalls, res, e, lat, read_seen);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = '0; addr = '0; rt_old = '0;
        mem_bus.mem_waitrequest = 1'b0; mem_bus.mem_readdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=0", result); end
        checks++; if (err !== 2'b00) begin failures++; $display("FAIL reset_err got=%b want=00", err); end
        checks++; if (mem_bus.mem_read !== 1'b0 || mem_bus.mem_address !== 32'h0 || mem_bus.mem_byteenable !== 4'h0) begin
            failures++; $display("FAIL reset_bus got=%b/%h/%h want=0/0/0", mem_bus.mem_read, mem_bus.mem_address, mem_bus.mem_byteenable); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_byte();
        int lat; logic [31:0] res; logic [1:0] e; bit rs, bb;
        run_load(3'b000, 32'h1003, 32'h0, 32'h80FF1234, 0, lat, res, e, rs, bb);
        checks++; if (res !== 32'hFFFFFF80 || e !== 2'b00 || lat != 2) begin failures++;
            $display("FAIL lb_1003 got=%h/%b/lat%0d want=ffffff80/00/lat2", res, e, lat); end
        checks++; if (bb) begin failures++; $display("FAIL lb_bus got=bad want=addr 00001000 be f"); end
        run_load(3'b100, 32'h1003, 32'h0, 32'h80FF1234, 0, lat, res, e, rs, bb);
        checks++; if (res !== 32'h00000080 || e !== 2'b00 || lat != 2) begin failures++;
            $display("FAIL lbu_1003 got=%h/%b/lat%0d want=00000080/00/lat2", res, e, lat); end
        run_load(3'b000, 32'h1000, 32'h0, 32'h80FF1234, 0, lat, res, e, rs, bb);
        checks++; if (res !== 32'h00000034) begin failures++; $display("FAIL lb_1000 got=%h want=00000034", res); end
        run_load(3'b100, 32'h1002, 32'h0, 32'h80FF1234, 0, lat, res, e, rs, bb);
        checks++; if (res !== 32'h000000FF) begin failures++; $display("FAIL lbu_1002 got=%h want=000000ff", res); end
        run_load(3'b000, 32'h1001, 32'h0, 32'h80FF1234, 0, lat, res, e, rs, bb);
        checks++; if (res !== 32'h00000012) begin failures++; $display("FAIL lb_1001 got=%h want=00000012", res); end
    endtask

    task automatic test_half();
        int lat; logic [31:0] res; logic [1:0] e; bit rs, bb;
        run_load(3'b001, 32'h1002, 32'h0, 32'h7FFD8000, 0, lat, res, e, rs, bb);
        checks++; if (res !== 32'h00007FFD || e !== 2'b00 || lat != 2) begin failures++;
            $display("FAIL lh_1002 got=%h/%b/lat%0d want=00007ffd/00/lat2", res, e, lat); end
        run_load(3'b001, 32'h1000, 32'h0, 32'h7FFD8000, 0, lat, res, e, rs, bb);
        checks++; if (res !== 32'hFFFF8000) begin failures++; $display("FAIL lh_1000 got=%h want=ffff8000", res); end
        run_load(3'b101, 32'h1000, 32'h0, 32'h7FFD8000, 0, lat, res, e, rs, bb);
        checks++; if (res !== 32'h00008000) begin failures++; $display("FAIL lhu_1000 got=%h want=00008000", res); end
        run_load(3'b101, 32'h1003, 32'h0, 32'h7FFD8000, 0, lat, res, e, rs, bb);
        checks++; if (e !== 2'b01 || res !== 32'h0 || lat != 1 || rs) begin failures++;
            $display("FAIL lhu_misalign got=%b/%h/lat%0d/read%0d want=01/0/lat1/read0", e, res, lat, rs); end
    endtask

    task automatic test_word();
        int lat; logic [31:0] res; logic [1:0] e; bit rs, bb;
        run_load(3'b011, 32'h2000, 32'h0, 32'hDEADBEEF, 0, lat, res, e, rs, bb);
        checks++; if (res !== 32'hDEADBEEF || e !== 2'b00 || lat != 2 || bb) begin failures++;
            $display("FAIL lw_2000 got=%h/%b/lat%0d/busbad%0d want=deadbeef/00/lat2/0", res, e, lat, bb); end
        // One cycle after the pulse: back to idle with cleared outputs.
        checks++; if (done !== 1'b0 || busy !== 1'b0 || result !== 32'h0 || err !== 2'b00) begin failures++;
            $display("FAIL done_one_cycle got=%b/%b/%h/%b want=0/0/0/00", done, busy, result, err); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] res; logic [1:0] e; bit rs, bb;
        run_load(3'b011, 32'h1001, 32'h0, 32'h12345678, 0, lat, res, e, rs, bb);
        checks++; if (e !== 2'b01 || res !== 32'h0 || lat != 1 || rs) begin failures++;
            $display("FAIL lw_misalign_1001 got=%b/%h/lat%0d/read%0d want=01/0/lat1/read0", e, res, lat, rs); end
        run_load(3'b011, 32'h1002, 32'h0, 32'h12345678, 0, lat, res, e, rs, bb);
        checks++; if (e !== 2'b01 || rs) begin failures++; $display("FAIL lw_misalign_1002 got=%b/read%0d want=01/read0", e, rs); end
        run_load(3'b111, 32'h1000, 32'h0, 32'h12345678, 0, lat, res, e, rs, bb);
        checks++; if (e !== 2'b10 || res !== 32'h0 || lat != 1 || rs) begin failures++;
            $display("FAIL op_illegal got=%b/%h/lat%0d/read%0d want=10/0/lat1/read0", e, res, lat, rs); end
    endtask

    task automatic test_stall();
        int lat; logic [31:0] res; logic [1:0] e; bit rs, bb;
        run_load(3'b011, 32'h2000, 32'h0, 32'h12345678, 3, lat, res, e, rs, bb);
        checks++; if (res !== 32'h12345678 || e !== 2'b00 || lat != 5) begin failures++;
            $display("FAIL lw_stall3 got=%h/%b/lat%0d want=12345678/00/lat5", res, e, lat); end
        checks++; if (bb || !rs) begin failures++; $display("FAIL stall_addr_hold got=busbad%0d/read%0d want=0/1", bb, rs); end
    endtask

    task automatic test_timeout();
        int lat; logic [31:0] res; logic [1:0] e; bit rs, bb;
        run_load(3'b011, 32'h2004, 32'h0, 32'h55AA55AA, 1000, lat, res, e, rs, bb);
        checks++; if (e !== 2'b11 || res !== 32'h0 || lat != 17) begin failures++;
            $display("FAIL timeout got=%b/%h/lat%0d want=11/0/lat17", e, res, lat); end
    endtask

    task automatic test_unaligned();
        int lat; logic [31:0] res; logic [1:0] e; bit rs, bb;
`ifdef UNALIGNED_LOAD_EN
        run_load(3'b010, 32'h1001, 32'h11223344, 32'hAABBCCDD, 0, lat, res, e, rs, bb);
        checks++; if (res !== 32'hCCDD3344 || e !== 2'b00 || lat != 2) begin failures++;
            $display("FAIL lwl_1001 got=%h/%b/lat%0d want=ccdd3344/00/lat2", res, e, lat); end
        run_load(3'b110, 32'h1001, 32'h11223344, 32'hAABBCCDD, 0, lat, res, e, rs, bb);
        checks++; if (res !== 32'h11AABBCC || e !== 2'b00 || lat != 2) begin failures++;
            $display("FAIL lwr_1001 got=%h/%b/lat%0d want=11aabbcc/00/lat2", res, e, lat); end
`else
        run_load(3'b010, 32'h1001, 32'h11223344, 32'hAABBCCDD, 0, lat, res, e, rs, bb);
        checks++; if (e !== 2'b10 || res !== 32'h0 || lat != 1 || rs) begin failures++;
            $display("FAIL lwl_disabled got=%b/%h/lat%0d/read%0d want=10/0/lat1/read0", e, res, lat, rs); end
        run_load(3'b110, 32'h1001, 32'h11223344, 32'hAABBCCDD, 0, lat, res, e, rs, bb);
        checks++; if (e !== 2'b10 || rs) begin failures++; $display("FAIL lwr_disabled got=%b/read%0d want=10/read0", e, rs); end
`endif
    endtask

    task automatic test_start_while_busy();
        int stall_cnt; bit addr_moved; bit got_done; logic [31:0] res;
        stall_cnt = 0; addr_moved = 0; got_done = 0; res = '0;
        @(negedge clk);
        start = 1'b1; op = 3'b011; addr = 32'h3000; rt_old = '0;
        mem_bus.mem_readdata = 32'h89ABCDEF; mem_bus.mem_waitrequest = 1'b0;
        @(posedge clk); #1;
        // Keep start asserted with a different request while busy.
        op = 3'b000; addr = 32'h3003;
        for (int k = 1; k <= 20; k++) begin
            if (mem_bus.mem_read) begin
                if (mem_bus.mem_address !== 32'h3000) addr_moved = 1;
                mem_bus.mem_waitrequest = (stall_cnt < 2);
                if (mem_bus.mem_waitrequest) stall_cnt++;
            end
            if (done) begin got_done = 1; res = result; break; end
            @(posedge clk); #1;
        end
        mem_bus.mem_waitrequest = 1'b0;
        $display("load op=3 addr=00003000 with start held -> result=%h done=%0d", res, got_done);
        checks++; if (!got_done || res !== 32'h89ABCDEF || addr_moved) begin failures++;
            $display("FAIL busy_start_ignored got=%h/done%0d/moved%0d want=89abcdef/1/0", res, got_done, addr_moved); end
        // start is still high across the DONE->IDLE edge and must be ignored.
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL done_start_ignored got=busy%b want=busy0", busy); end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_read();
        int lat; logic [31:0] res; logic [1:0] e; bit rs, bb; bit saw_done;
        saw_done = 0;
        @(negedge clk);
        start = 1'b1; op = 3'b011; addr = 32'h4000; mem_bus.mem_waitrequest = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (mem_bus.mem_read !== 1'b1) begin failures++; $display("FAIL pre_reset_read got=%b want=1", mem_bus.mem_read); end
        #2 reset = 1'b1;
        #1;
        checks++; if (mem_bus.mem_read !== 1'b0 || mem_bus.mem_address !== 32'h0 || busy !== 1'b0) begin failures++;
            $display("FAIL async_reset_drop got=%b/%h/busy%b want=0/0/busy0", mem_bus.mem_read, mem_bus.mem_address, busy); end
        @(negedge clk); @(negedge clk);
        reset = 1'b0; mem_bus.mem_waitrequest = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) saw_done = 1;
        end
        $display("reset mid-read -> done_after_reset=%0d", saw_done);
        checks++; if (saw_done) begin failures++; $display("FAIL no_done_after_reset got=1 want=0"); end
        run_load(3'b011, 32'h4000, 32'h0, 32'hCAFEF00D, 0, lat, res, e, rs, bb);
        checks++; if (res !== 32'hCAFEF00D || e !== 2'b00 || lat != 2) begin failures++;
            $display("FAIL after_reset_load got=%h/%b/lat%0d want=cafef00d/00/lat2", res, e, lat); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_byte();
        test_half();
        test_word();
        test_errors();
        test_stall();
        test_timeout();
        test_unaligned();
        test_start_while_busy();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
